seq_detector_param: RTL and testbench

//  Parametrised serial bit-pattern detector; successor to the fixed 1011 Mealy/Moore detectors.

---
 rtl/seq_det_pkg.sv | 11 +
 rtl/seq_match_counter.sv | 37 +++
 rtl/seq_detector_param.sv | 96 +++++++++
 tb/tb_seq_detector_param.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// Imported by the detector top and its match counter.
package seq_det_pkg;

    localparam int MAX_PAT_LEN = 32;

    function automatic int fill_w(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with synchronous clear.
// Clear wins over a same-cycle increment.
module seq_match_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with reloadable pattern,
// selectable overlap policy, Mealy/Moore output and a match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 OVERLAP = 1,
    parameter int                 MOORE   = 0,
    parameter int                 CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               clr_cnt,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int FW = fill_w(PAT_LEN);
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_LEN);
    localparam logic [FW-1:0] FILL_THR  = FW'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [PAT_LEN-1:0] win;
    logic               hit;

    assign win = {hist_q[PAT_LEN-2:0], in_bit};

    // Gating with rst keeps the Mealy output and counter quiet during reset.
    assign hit = in_valid & ~cfg_load & ~rst
               & (fill_q >= FILL_THR) & (win == pat_q);

    always_comb begin
        hist_d = hist_q;
        pat_d  = pat_q;
        fill_d = fill_q;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            if (hit && (OVERLAP == 0)) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = win;
                fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            pat_q  <= PATTERN;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            pat_q  <= pat_d;
            fill_q <= fill_d;
        end
    end

    generate
        if (MOORE != 0) begin : g_moore
            logic match_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    match_q <= 1'b0;
                end else begin
                    match_q <= hit;
                end
            end
            assign match = match_q;
        end else begin : g_mealy
            assign match = hit;
        end
    endgenerate

    seq_match_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk(clk),
        .rst(rst),
        .inc(hit),
        .clr(clr_cnt),
        .cnt(match_cnt)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: four builds share one stimulus
// stream (default, non-overlap, Moore, 2-bit counter).
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_bit;
    logic       cfg_load;
    logic [3:0] cfg_pattern;
    logic       clr_cnt;

    logic       m_a, m_b, m_c, m_d;
    logic [7:0] cnt_a, cnt_b, cnt_c;
    logic [1:0] cnt_d;

    int total = 0;
    int bad = 0;
    string tname = "init";

    typedef struct {
        int    idx;
        logic  e;
        string tag;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    seq_detector_param u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .clr_cnt(clr_cnt),
        .match(m_a), .match_cnt(cnt_a)
    );

    seq_detector_param #(.OVERLAP(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .clr_cnt(clr_cnt),
        .match(m_b), .match_cnt(cnt_b)
    );

    seq_detector_param #(.MOORE(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .clr_cnt(clr_cnt),
        .match(m_c), .match_cnt(cnt_c)
    );

    seq_detector_param #(.CNT_W(2)) u_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .clr_cnt(clr_cnt),
        .match(m_d), .match_cnt(cnt_d)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_m(input int idx);
        case (idx)
            0: return m_a;
            1: return m_b;
            2: return m_c;
            default: return m_d;
        endcase
    endfunction

    task automatic ex(input int idx, input logic e);
        exp_t t;
        t.idx = idx;
        t.e   = e;
        t.tag = $sformatf("%s_m%0d", tname, idx);
        q.push_back(t);
    endtask

    // Entered at posedge+1; checks queued expectations 1 time unit before the edge.
    task automatic tick();
        exp_t t;
        #8;
        while (q.size() > 0) begin
            t = q.pop_front();
            chk(t.tag, 32'(get_m(t.idx)), 32'(t.e));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic b);
        rst      = 1'b0;
        cfg_load = 1'b0;
        clr_cnt  = 1'b0;
        in_valid = v;
        in_bit   = b;
        tick();
    endtask

    // MSB of each vector is the first cycle.
    task automatic run(input int n, input logic [31:0] vv,
                       input logic [31:0] bb,
                       input int i0, input logic [31:0] e0,
                       input int i1, input logic [31:0] e1);
        for (int k = n - 1; k >= 0; k--) begin
            ex(i0, e0[k]);
            if (i1 >= 0) ex(i1, e1[k]);
            drive(vv[k], bb[k]);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        cfg_load    = 1'b0;
        clr_cnt     = 1'b0;
        cfg_pattern = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = 4'b0000;
        clr_cnt     = 1'b0;
        @(posedge clk);
        #1;

        tname = "rst";
        do_reset();
        chk("rst_m_a", 32'(m_a), 0);
        chk("rst_m_c", 32'(m_c), 0);
        chk("rst_cnt_a", 32'(cnt_a), 0);
        chk("rst_cnt_d", 32'(cnt_d), 0);

        tname = "ovl";
        run(7, '1, 32'b1011011, 0, 32'b0001001, 1, 32'b0001000);
        chk("ovl_cnt_a", 32'(cnt_a), 2);
        chk("novl_cnt_b", 32'(cnt_b), 1);
        run(4, '1, 32'b1011, 0, 32'b0001, 1, 32'b0001);
        chk("ovl_cnt_a2", 32'(cnt_a), 3);
        chk("novl_cnt_b2", 32'(cnt_b), 2);

        tname = "moore";
        do_reset();
        run(11, 32'b10100101000, 32'b10010101101,
            2, 32'b00000000100, 0, 32'b00000001000);
        chk("moore_cnt_c", 32'(cnt_c), 1);
        chk("moore_cnt_a", 32'(cnt_a), 1);

        tname = "load";
        do_reset();
        run(3, '1, 32'b011, 0, 0, -1, 0);
        cfg_load    = 1'b1;
        cfg_pattern = 4'b0110;
        in_valid    = 1'b0;
        ex(0, 1'b0);
        tick();
        run(1, '1, 32'b0, 0, 0, -1, 0);
        run(4, '1, 32'b0110, 0, 32'b0001, -1, 0);
        chk("load_cnt_a", 32'(cnt_a), 1);
        run(3, '1, 32'b011, 0, 0, -1, 0);
        cfg_load    = 1'b1;
        cfg_pattern = 4'b0110;
        in_valid    = 1'b1;
        in_bit      = 1'b0;
        ex(0, 1'b0);
        tick();
        chk("load_drop_cnt", 32'(cnt_a), 1);
        run(3, '1, 32'b110, 0, 0, -1, 0);
        run(4, '1, 32'b0110, 0, 32'b0001, -1, 0);
        chk("load_cnt_a2", 32'(cnt_a), 2);

        tname = "sat";
        do_reset();
        run(16, '1, 32'b1011011011011011, 3, 32'b0001001001001001,
            -1, 0);
        chk("sat_cnt_d", 32'(cnt_d), 3);
        chk("sat_cnt_a", 32'(cnt_a), 5);
        run(2, '1, 32'b01, 3, 0, -1, 0);
        rst      = 1'b0;
        cfg_load = 1'b0;
        clr_cnt  = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        ex(3, 1'b1);
        tick();
        chk("clr_cnt_d", 32'(cnt_d), 0);
        run(3, '1, 32'b011, 3, 32'b001, -1, 0);
        chk("clr_cnt_d2", 32'(cnt_d), 1);
        chk("clr_cnt_a", 32'(cnt_a), 1);

        tname = "midrst";
        run(3, '1, 32'b101, 0, 0, -1, 0);
        rst      = 1'b1;
        cfg_load = 1'b0;
        clr_cnt  = 1'b0;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        ex(0, 1'b0);
        ex(1, 1'b0);
        ex(3, 1'b0);
        tick();
        ex(0, 1'b0);
        ex(1, 1'b0);
        ex(2, 1'b0);
        ex(3, 1'b0);
        drive(1'b1, 1'b1);
        chk("midrst_cnt_a", 32'(cnt_a), 0);
        chk("midrst_cnt_c", 32'(cnt_c), 0);
        chk("midrst_cnt_d", 32'(cnt_d), 0);
        chk("midrst_m_c", 32'(m_c), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
